mult32b: RTL and testbench
==========================

# mult32b

Pipelined 32×32 → 64-bit integer multiplier used as the arithmetic core of the datapath's multiply unit. It accepts one operand pair per clock and returns the full-width product two cycles later. Results carry a valid flag so the surrounding control can track in-flight operations. The default build is unsigned; a compile-time option switches it to two's-complement.

## Interface
- No parameters; widths fixed at 32-bit operands and 64-bit product.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a/b hold a new operand pair this cycle.
- a  input  32  multiplicand.
- b  input  32  multiplier.
- out_valid  output  1  prod holds a new result this cycle.
- prod  output  64  full product a×b, registered.

## Operation
- Stage 1, sampled at the clock edge on which in_valid=1:
  - a and b are split into 16-bit halves.
  - Four 16×16 partial products are computed (aL·bL, aL·bH, aH·bL, aH·bH), each 32 bits wide.
  - The partial products are registered together with a stage valid bit.
- Stage 2: prod = aH·bH·2^32 + (aL·bH + aH·bL)·2^16 + aL·bL.
  - Summed in 64-bit arithmetic with no truncation; the full product always fits in 64 bits.
  - Result and out_valid are registered.
- When in_valid=0, the stage-1 valid bit is cleared.
  - Partial-product registers may hold stale data.
  - prod holds its last value whenever out_valid=0; it changes only on cycles where stage-2 valid is 1.
- No stall and no backpressure: every accepted pair produces exactly one result, in issue order.
- Zero operands: prod=0. There is no overflow condition.

## Timing
- Latency: 2 clock edges.
  - Pair presented with in_valid=1 before edge N.
  - prod/out_valid updated at edge N+1, visible after it.
- Throughput: one pair per cycle. Back-to-back pairs produce back-to-back results.
- Reset, rst_n=0, asynchronous and independent of clk:
  - prod=0, out_valid=0.
  - All pipeline registers and valid bits cleared.
- Reset mid-operation: in-flight operations are discarded and never emerge.
  - After rst_n deasserts, the first out_valid occurs 2 edges after the first accepted in_valid.
- Outputs are purely registered; there is no combinational path from inputs to prod/out_valid.

## Configuration
- Macro MULT32B_SIGNED_EN.
- Undefined (default): operands and product are unsigned.
- Defined: operands and product are two's-complement.
  - Stage 1 registers the product sign (a[31]^b[31]) and multiplies the magnitudes.
  - Stage 2 negates the 64-bit sum when the sign is 1.
  - Magnitude of −2^31 is 2^31, computed as a 32-bit unsigned value.
  - (−2^31)×(−2^31) = 0x4000000000000000.
- Latency and port list are identical in both builds.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle, then release.
  - Required: prod=0 and out_valid=0 immediately on assertion.
  - Required: no out_valid until 2 edges after the next in_valid.
- Unsigned basics: a=3, b=7 → prod=21 after 2 edges; a=0, b=0xFFFFFFFF → prod=0.
- Unsigned maximum: a=b=0xFFFFFFFF → prod=0xFFFFFFFE00000001.
- Streaming: 5 consecutive pairs from a seeded random source with in_valid=1.
  - Required: 5 consecutive out_valid pulses, each prod equal to the 64-bit reference product, in order.
- Reset during flight: issue a=2, b=5 then assert rst_n=0 before 2 edges elapse.
  - Required: no result 10 ever appears.
- Signed build (MULT32B_SIGNED_EN):
  - a=0xFFFFFFFF, b=0xFFFFFFFF → prod=1.
  - a=0xFFFFFFFE, b=3 → prod=0xFFFFFFFFFFFFFFFA.
  - a=b=0x80000000 → prod=0x4000000000000000.

Source files
------------

// File: rtl/mult32b.sv
// mult32b: two-stage 32x32->64 multiplier.
// Build option: MULT32B_SIGNED_EN selects two's-complement.
module mult32b (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [63:0] prod
);

    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] ll_d;
    logic [31:0] lh_d;
    logic [31:0] hl_d;
    logic [31:0] hh_d;

    logic        v1;
    logic [31:0] pp_ll;
    logic [31:0] pp_lh;
    logic [31:0] pp_hl;
    logic [31:0] pp_hh;

    logic [32:0] mid;
    logic [63:0] sum;
    logic [63:0] res;

`ifdef MULT32B_SIGNED_EN
    logic        sgn_d;
    logic        sgn1;

    // Operand magnitudes; -2^31 maps to 2^31 as unsigned.
    always_comb begin
        ma    = a[31] ? (~a + 32'd1) : a;
        mb    = b[31] ? (~b + 32'd1) : b;
        sgn_d = a[31] ^ b[31];
    end
`else
    // Unsigned build multiplies the operands directly.
    always_comb begin
        ma = a;
        mb = b;
    end
`endif

    // Four 16x16 partial products of the magnitudes.
    always_comb begin
        ll_d = {16'd0, ma[15:0]}  * {16'd0, mb[15:0]};
        lh_d = {16'd0, ma[15:0]}  * {16'd0, mb[31:16]};
        hl_d = {16'd0, ma[31:16]} * {16'd0, mb[15:0]};
        hh_d = {16'd0, ma[31:16]} * {16'd0, mb[31:16]};
    end

    // Stage 1: register partial products and valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            pp_ll <= 32'd0;
            pp_lh <= 32'd0;
            pp_hl <= 32'd0;
            pp_hh <= 32'd0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                pp_ll <= ll_d;
                pp_lh <= lh_d;
                pp_hl <= hl_d;
                pp_hh <= hh_d;
            end
        end
    end

`ifdef MULT32B_SIGNED_EN
    // Stage 1: product sign travels with the partials.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn1 <= 1'b0;
        end else if (in_valid) begin
            sgn1 <= sgn_d;
        end
    end
`endif

    // Recombine partials in 64 bits; cross terms carry into bit 48.
    always_comb begin
        mid = {1'b0, pp_lh} + {1'b0, pp_hl};
        sum = {pp_hh, pp_ll} + {15'd0, mid, 16'd0};
`ifdef MULT32B_SIGNED_EN
        res = sgn1 ? (~sum + 64'd1) : sum;
`else
        res = sum;
`endif
    end

    // Stage 2: result only updates on a valid slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            prod      <= 64'd0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                prod <= res;
            end
        end
    end

endmodule

// File: tb/tb_mult32b.sv
// tb_mult32b: directed checks for mult32b.
// Covers reset, latency, streaming, and the active build mode.
module tb_mult32b;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [63:0] prod;

    int tests;
    int fails;

    logic [31:0] sa [5];
    logic [31:0] sb [5];
    logic [63:0] sref [5];

    mult32b dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .prod      (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] refp(input logic [31:0] x,
                                         input logic [31:0] y);
`ifdef MULT32B_SIGNED_EN
        longint sx;
        longint sy;
        sx = longint'(int'(x));
        sy = longint'(int'(y));
        return 64'(sx * sy);
`else
        return {32'd0, x} * {32'd0, y};
`endif
    endfunction

    // One isolated operation: checks latency, value and hold.
    task automatic do_op(input string tag,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         input logic [63:0] exp);
        @(negedge clk);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_prod"}, prod, exp);
        @(negedge clk);
        chk({tag, "_vld_off"}, 64'(out_valid), 64'd0);
        chk({tag, "_hold"}, prod, exp);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 32'd0;
        b        = 32'd0;

        #3;
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_prod", prod, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("mul3x7", 32'd3, 32'd7, 64'd21);
        do_op("zero", 32'd0, 32'hFFFF_FFFF, 64'd0);

`ifdef MULT32B_SIGNED_EN
        do_op("s_m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              64'd1);
        do_op("s_m2x3", 32'hFFFF_FFFE, 32'd3,
              64'hFFFF_FFFF_FFFF_FFFA);
        do_op("s_min", 32'h8000_0000, 32'h8000_0000,
              64'h4000_0000_0000_0000);
`else
        do_op("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              64'hFFFF_FFFE_0000_0001);
        do_op("u_min", 32'h8000_0000, 32'h8000_0000,
              64'h4000_0000_0000_0000);
`endif

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(out_valid), 64'd0);
        chk("arst_prod", prod, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_vld", 64'(out_valid), 64'd0);
        end
        do_op("post_rst", 32'h0001_0000, 32'h0001_0000,
              64'h0000_0001_0000_0000);

        // Streaming: five back-to-back pairs.
        void'($urandom(32'd1234));
        for (int i = 0; i < 5; i++) begin
            sa[i]   = $urandom;
            sb[i]   = $urandom;
            sref[i] = refp(sa[i], sb[i]);
        end
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                chk($sformatf("strm%0d_vld", k - 2),
                    64'(out_valid), 64'd1);
                chk($sformatf("strm%0d_prod", k - 2),
                    prod, sref[k - 2]);
            end
            if (k < 5) begin
                a        = sa[k];
                b        = sb[k];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("strm_end_vld", 64'(out_valid), 64'd0);
        chk("strm_end_hold", prod, sref[4]);

        // Reset while 2x5 is in flight.
        @(negedge clk);
        a        = 32'd2;
        b        = 32'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("flt_rst_vld", 64'(out_valid), 64'd0);
        chk("flt_rst_prod", prod, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flt_vld", 64'(out_valid), 64'd0);
            chk("flt_prod", prod, 64'd0);
        end

        do_op("after_flt", 32'd6, 32'd9, 64'd54);

        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end

endmodule
